// File: rtl/solver_feeder.sv
// solver_feeder: host-side initiator for one solver instance.
// Optional watchdog: define SOLVER_FEEDER_TIMEOUT_EN.
//
// Flow: a point arrives on pt_*. Dirty limb-count and iteration-limit
// shadows are pushed first. The limbs are then written, the solver is
// started, and its iteration count comes back tagged on res_*.
//
// Ports:
//   clock, reset           clock, async active-high reset
//   cfg_num_limbs[_en]     limb-count shadow write
//   cfg_iter_lim[_en]      iteration-limit shadow write
//   pt_valid/pt_ready      point limb stream (pt_real, pt_imag, pt_last, pt_tag)
//   wr_*_en, wr_index      solver limb/config write port (registered)
//   real_data, imag_data
//   num_limbs_data, iter_lim_data
//   start                  solver start pulse (registered)
//   out_ready, iterations  solver done/idle flag and result
//   res_valid/res_ready    result stream (res_iterations, res_tag)
//   err_len                sticky: beat count differed from num_limbs
//   timeout                sticky watchdog flag (0 without the watchdog)
module solver_feeder #(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_SIZE_BITS  = 27,
  parameter int TAG_BITS        = 16,
  parameter int TIMEOUT_BITS    = 24
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cfg_num_limbs_en,
  input  logic [LIMB_INDEX_BITS-1:0] cfg_num_limbs,
  input  logic                       cfg_iter_lim_en,
  input  logic [15:0]                cfg_iter_lim,
  input  logic                       pt_valid,
  output logic                       pt_ready,
  input  logic [LIMB_SIZE_BITS-1:0]  pt_real,
  input  logic [LIMB_SIZE_BITS-1:0]  pt_imag,
  input  logic                       pt_last,
  input  logic [TAG_BITS-1:0]        pt_tag,
  output logic                       wr_real_en,
  output logic                       wr_imag_en,
  output logic [LIMB_INDEX_BITS-1:0] wr_index,
  output logic [LIMB_SIZE_BITS-1:0]  real_data,
  output logic [LIMB_SIZE_BITS-1:0]  imag_data,
  output logic                       wr_num_limbs_en,
  output logic [LIMB_INDEX_BITS-1:0] num_limbs_data,
  output logic                       wr_iter_lim_en,
  output logic [15:0]                iter_lim_data,
  output logic                       start,
  input  logic                       out_ready,
  input  logic [15:0]                iterations,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [15:0]                res_iterations,
  output logic [TAG_BITS-1:0]        res_tag,
  output logic                       err_len,
  output logic                       timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_LOAD,
    S_START,
    S_WAIT_LO,
    S_WAIT_HI,
    S_RESULT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [LIMB_INDEX_BITS-1:0] r_nl_shadow;
  logic [15:0]                r_il_shadow;
  logic                       r_nl_dirty;
  logic                       r_il_dirty;
  logic [LIMB_INDEX_BITS-1:0] r_idx;
  logic [LIMB_INDEX_BITS:0]   r_beats;
  logic [LIMB_INDEX_BITS:0]   w_beat_cnt;

  logic w_beat;
  logic w_go_cfg;
  logic w_done;
  logic w_wdog_fire;

  assign pt_ready   = (r_state == S_LOAD);
  assign res_valid  = (r_state == S_RESULT);
  assign w_beat     = (r_state == S_LOAD) && pt_valid;
  assign w_done     = (r_state == S_WAIT_HI) && out_ready;
  assign w_beat_cnt = r_beats + 1'b1;

  // A waiting point may enter CFG straight from a completed handshake.
  assign w_go_cfg = pt_valid &&
    ((r_state == S_IDLE) ||
     ((r_state == S_RESULT) && res_ready));

`ifdef SOLVER_FEEDER_TIMEOUT_EN
  localparam logic [TIMEOUT_BITS-1:0] WDOG_LAST =
    {TIMEOUT_BITS{1'b1}} - 1'b1;

  logic [TIMEOUT_BITS-1:0] r_wdog;
  logic                    r_timeout;
  logic                    w_waiting;

  assign w_waiting =
    (r_state == S_WAIT_LO) || (r_state == S_WAIT_HI);
  // r_wdog counts completed wait cycles; fire on the last allowed one.
  assign w_wdog_fire = w_waiting && (r_wdog == WDOG_LAST);
  assign timeout = r_timeout;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_waiting && !w_wdog_fire)
        r_wdog <= r_wdog + 1'b1;
      else
        r_wdog <= '0;
      if (w_wdog_fire)
        r_timeout <= 1'b1;
    end
  end
`else
  assign w_wdog_fire = 1'b0;
  // Constant 0; the comparison only keeps the parameter referenced.
  assign timeout = (TIMEOUT_BITS < 0);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (pt_valid) w_next = S_CFG;
      S_CFG:     w_next = S_LOAD;
      S_LOAD:    if (w_beat && pt_last) w_next = S_START;
      S_START:   w_next = S_WAIT_LO;
      S_WAIT_LO: begin
        if (w_wdog_fire)     w_next = S_RESULT;
        else if (!out_ready) w_next = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (w_wdog_fire || out_ready) w_next = S_RESULT;
      end
      S_RESULT: begin
        if (res_ready) w_next = pt_valid ? S_CFG : S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_nl_shadow     <= LIMB_INDEX_BITS'(1);
      r_il_shadow     <= 16'd256;
      r_nl_dirty      <= 1'b1;
      r_il_dirty      <= 1'b1;
      r_idx           <= '0;
      r_beats         <= '0;
      wr_real_en      <= 1'b0;
      wr_imag_en      <= 1'b0;
      wr_index        <= '0;
      real_data       <= '0;
      imag_data       <= '0;
      wr_num_limbs_en <= 1'b0;
      num_limbs_data  <= LIMB_INDEX_BITS'(1);
      wr_iter_lim_en  <= 1'b0;
      iter_lim_data   <= 16'd256;
      start           <= 1'b0;
      res_iterations  <= '0;
      res_tag         <= '0;
      err_len         <= 1'b0;
    end else begin
      wr_real_en      <= 1'b0;
      wr_imag_en      <= 1'b0;
      wr_num_limbs_en <= 1'b0;
      wr_iter_lim_en  <= 1'b0;
      start           <= (r_state == S_START);

      // Strobes are registered, so the pulses are set up on entry to CFG.
      if (w_go_cfg) begin
        wr_num_limbs_en <= r_nl_dirty;
        wr_iter_lim_en  <= r_il_dirty;
        if (r_nl_dirty) num_limbs_data <= r_nl_shadow;
        if (r_il_dirty) iter_lim_data  <= r_il_shadow;
        r_idx   <= '0;
        r_beats <= '0;
      end

      // A host write on the send edge keeps its dirty bit for the next point.
      if (cfg_num_limbs_en) begin
        r_nl_shadow <= cfg_num_limbs;
        r_nl_dirty  <= 1'b1;
      end else if (w_go_cfg) begin
        r_nl_dirty  <= 1'b0;
      end

      if (cfg_iter_lim_en) begin
        r_il_shadow <= cfg_iter_lim;
        r_il_dirty  <= 1'b1;
      end else if (w_go_cfg) begin
        r_il_dirty  <= 1'b0;
      end

      if (w_beat) begin
        wr_real_en <= 1'b1;
        wr_imag_en <= 1'b1;
        wr_index   <= r_idx;
        real_data  <= pt_real;
        imag_data  <= pt_imag;
        r_idx      <= r_idx + 1'b1;
        if (r_beats != '1)
          r_beats <= w_beat_cnt;
        if (r_beats == '0)
          res_tag <= pt_tag;
        if (pt_last && (w_beat_cnt != {1'b0, num_limbs_data}))
          err_len <= 1'b1;
      end

      if (w_wdog_fire)
        res_iterations <= 16'hFFFF;
      else if (w_done)
        res_iterations <= iterations;
    end
  end

endmodule

// File: doc/solver_feeder.md
# solver_feeder

Host-side initiator for one `solver` instance. It accepts a tagged point (c real/imag limbs, last limb flagged) on a valid/ready stream and pushes any pending limb-count or iteration-limit configuration. It then writes the limbs through the solver's limb-write port, issues `start`, waits for the solver to finish, and returns the iteration count with the point's tag on a valid/ready result stream. It sits between the point dispatcher and the solver, one feeder per solver.

## Interface
- `LIMB_INDEX_BITS`, default 6: limb index width; must match the solver.
- `LIMB_SIZE_BITS`, default 27: limb width; must match the solver.
- `TAG_BITS`, default 16: opaque point tag carried from point to result.
- `TIMEOUT_BITS`, default 24: watchdog counter width; used only with `SOLVER_FEEDER_TIMEOUT_EN`.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `cfg_num_limbs_en`  in  1: load `cfg_num_limbs` into the shadow register.
- `cfg_num_limbs`  in  LIMB_INDEX_BITS: limbs per coordinate.
- `cfg_iter_lim_en`  in  1: load `cfg_iter_lim` into the shadow register.
- `cfg_iter_lim`  in  16: iteration limit.
- `pt_valid` / `pt_ready`  in / out  1: point limb handshake.
- `pt_real`, `pt_imag`  in  LIMB_SIZE_BITS: limb pair, index 0 first.
- `pt_last`  in  1: final limb of the point.
- `pt_tag`  in  TAG_BITS: tag, sampled on the first limb.
- `wr_real_en`, `wr_imag_en`  out  1: solver c-limb write strobes.
- `wr_index`  out  LIMB_INDEX_BITS: solver limb index.
- `real_data`, `imag_data`  out  LIMB_SIZE_BITS: solver limb data.
- `wr_num_limbs_en`  out  1; `num_limbs_data`  out  LIMB_INDEX_BITS.
- `wr_iter_lim_en`  out  1; `iter_lim_data`  out  16.
- `start`  out  1: solver start pulse.
- `out_ready`  in  1: solver finished/idle.
- `iterations`  in  16: solver result.
- `res_valid` / `res_ready`  out / in  1: result handshake.
- `res_iterations`  out  16; `res_tag`  out  TAG_BITS.
- `err_len`  out  1: sticky flag; limb count differed from num_limbs.
- `timeout`  out  1: sticky watchdog flag; constant 0 when the watchdog is not compiled in.

## Operation
- States: IDLE → CFG → LOAD → START → WAIT_LO → WAIT_HI → RESULT → IDLE.
- **Shadow registers:**
  - Shadows reset to num_limbs=1, iter_lim=256, and both dirty bits set.
  - Writes to the shadows are accepted in any state; each write sets that shadow's dirty bit.
  - A change made mid-job applies to the next point.
- **IDLE:** on `pt_valid`, go to CFG. The point is not consumed yet.
- **CFG:** one cycle.
  - Pulse `wr_num_limbs_en` if num_limbs is dirty, and `wr_iter_lim_en` if iter_lim is dirty. Both may pulse in the same cycle.
  - Clear the dirty bits that were sent, then go to LOAD.
  - A cfg write landing in the same cycle re-sets its dirty bit and wins.
- **LOAD:**
  - `pt_ready`=1. Each accepted beat produces one write with both strobes high at index `idx`, then `idx` increments; `idx` starts at 0.
  - `idx` wraps at 2^LIMB_INDEX_BITS.
  - If beat count ≠ num_limbs when `pt_last` is accepted, set `err_len` and continue normally.
  - Accepting `pt_last` goes to START.
- **START:** pulse `start` for one cycle, then go to WAIT_LO.
- **WAIT_LO:** wait for `out_ready`=0. This rejects a stale high `out_ready` left over from the previous job.
- **WAIT_HI:** on `out_ready`=1, capture `iterations` into `res_iterations` and go to RESULT.
- **RESULT:** `res_valid`=1 with tag and iterations held stable until `res_ready`, then go to IDLE.
- **Reset:** asynchronous reset at any point returns to IDLE and restores the shadow reset values with dirty bits set. An in-flight point is dropped.

## Timing
- Reset values:
  - Every strobe, `start`, `pt_ready`, `res_valid`, `err_len` and `timeout` are 0.
  - `wr_index`, data outputs, `res_iterations` and `res_tag` are 0.
  - `num_limbs_data`=1 and `iter_lim_data`=256.
- All solver-side outputs are registered.
- A beat accepted at edge N shows its write strobes during cycle N+1.
- `start` asserts in the cycle after the last write strobe.
- An `out_ready` high sampled at edge M gives `res_valid`=1 from cycle M+1.
- Minimum spacing: pt_valid → CFG is 1 cycle, then 1 CFG cycle before the first `pt_ready`.
- Back-to-back points: the next CFG begins the cycle after the result handshake completes.

## Configuration
- `SOLVER_FEEDER_TIMEOUT_EN` defined:
  - The watchdog counts cycles in WAIT_LO and WAIT_HI.
  - At 2^TIMEOUT_BITS−1 it forces RESULT with `res_iterations`=16'hFFFF and sets `timeout`.
- Not defined: no counter; `timeout` is tied to 0 and the feeder waits indefinitely.

## Test plan
- After reset with no cfg writes, send a 1-limb point (tag 5), solver returns 37 → CFG pulses both enables (1, 256), one write at index 0, `start`, result {37, tag 5}.
- Set num_limbs=3 and iter_lim=1000, send a 3-beat point with `pt_valid` gapped → indices 0, 1, 2 written in order; no cfg pulse for the second identical-config job.
- Stale `out_ready`: solver holds `out_ready`=1 for 2 cycles after `start` → the feeder does not capture until it has seen low followed by high.
- Hold `res_ready`=0 for 10 cycles → `res_valid` and the data stay stable and `pt_ready` stays 0; the next point starts only after the handshake.
- num_limbs=4, send 2 beats ending with `pt_last` → `err_len`=1 and the job still completes.
- With `SOLVER_FEEDER_TIMEOUT_EN` and TIMEOUT_BITS=4, `out_ready` is never asserted → result 16'hFFFF after 15 cycles and `timeout`=1; assert reset mid-LOAD → all outputs return to their reset values.
